// File: rtl/led_pwm_fader_if.sv
// rtl/led_pwm_fader_if.sv - pattern/enable in, LED drive/busy out bundle for the LED PWM fader
interface led_pwm_fader_if #(
    parameter int N_LEDS = 10
);
    logic [N_LEDS-1:0] pattern_in;
    logic              enable;
    logic [N_LEDS-1:0] led_out;
    logic              busy;

    modport master (
        output pattern_in, enable,
        input  led_out, busy
    );

    modport slave (
        input  pattern_in, enable,
        output led_out, busy
    );
endinterface

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - per-LED PWM driver with linear brightness ramps between on/off targets
module led_pwm_fader #(
    parameter int N_LEDS    = 10,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 50000,
    parameter int FADE_STEP = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    led_pwm_fader_if.slave  bus
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   MAX_X  = {1'b0, MAX};
    localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(FADE_STEP);
    localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);

    logic [N_LEDS-1:0]   pattern_q;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] duty_q [N_LEDS];
    logic [PWM_BITS-1:0] duty_d [N_LEDS];
    logic [PWM_BITS-1:0] target [N_LEDS];
    logic [PWM_BITS:0]   sum_c  [N_LEDS];
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                busy_q, busy_d;
    logic                step_tick;

    // Prescaler only runs in fade mode so enabling always starts a full step period.
    assign step_tick = bus.enable && (presc_q == PS_LAST);

    always_comb begin
        presc_d = '0;
        if (bus.enable && (presc_q != PS_LAST)) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        busy_d = 1'b0;
        led_d  = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            target[i] = pattern_q[i] ? MAX : '0;
            sum_c[i]  = {1'b0, duty_q[i]} + STEP_X;
            duty_d[i] = duty_q[i];
            if (!bus.enable) begin
                duty_d[i] = target[i];
            end else if (step_tick) begin
                // The add is one bit wider so a step past MAX saturates instead of wrapping.
                if (pattern_q[i] && (duty_q[i] != MAX)) begin
                    duty_d[i] = (sum_c[i] > MAX_X) ? MAX : sum_c[i][PWM_BITS-1:0];
                end else if (!pattern_q[i] && (duty_q[i] != '0)) begin
                    duty_d[i] = (duty_q[i] > STEP_N) ? (duty_q[i] - STEP_N) : '0;
                end
            end
            led_d[i] = bus.enable ? ((duty_q[i] == MAX) || (duty_q[i] > pwm_q)) : pattern_q[i];
            if (duty_d[i] != target[i]) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= '0;
            presc_q   <= '0;
            pwm_q     <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            pattern_q <= bus.pattern_in;
            presc_q   <= presc_d;
            pwm_q     <= pwm_q + 1'b1;
            led_q     <= led_d;
            busy_q    <= busy_d;
            for (int i = 0; i < N_LEDS; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - randomized and directed bench for led_pwm_fader against a cycle reference model
module tb_led_pwm_fader;
    localparam int N    = 10;
    localparam int PB   = 4;
    localparam int MAXV = 15;
    localparam int PS   = 4;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_pwm_fader_if #(.N_LEDS(N)) bus ();

    led_pwm_fader #(
        .N_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .FADE_STEP(STEP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    int m_duty [N];
    int m_pq, m_ps, m_pwm, m_led, m_busy;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_duty[i] = 0;
        m_pq = 0; m_ps = 0; m_pwm = 0; m_led = 0; m_busy = 0;
    endtask

    // One clock of the behavioural rules, all from pre-edge state and the sampled inputs.
    task automatic model_step(input int pin, input int en);
        int nd [N];
        int tick, led, busy, tgt;
        tick = (en != 0) && (m_ps == PS - 1);
        led = 0;
        busy = 0;
        for (int i = 0; i < N; i++) begin
            tgt = ((m_pq >> i) & 1) ? MAXV : 0;
            if (en == 0) nd[i] = tgt;
            else if (tick && ((m_pq >> i) & 1)) nd[i] = (m_duty[i] + STEP > MAXV) ? MAXV : m_duty[i] + STEP;
            else if (tick) nd[i] = (m_duty[i] - STEP < 0) ? 0 : m_duty[i] - STEP;
            else nd[i] = m_duty[i];
            if (en == 0) led |= ((m_pq >> i) & 1) << i;
            else if (m_duty[i] == MAXV || m_duty[i] > m_pwm) led |= 1 << i;
            if (nd[i] != tgt) busy = 1;
        end
        for (int i = 0; i < N; i++) m_duty[i] = nd[i];
        m_ps   = (en == 0) ? 0 : (m_ps + 1) % PS;
        m_pwm  = (m_pwm + 1) % (MAXV + 1);
        m_led  = led;
        m_busy = busy;
        m_pq   = pin;
    endtask

    task automatic cycle();
        int pin, en;
        @(posedge clk);
        pin = int'(bus.pattern_in);
        en  = int'(bus.enable);
        model_step(pin, en);
        #1;
        check("led_out", int'(bus.led_out), m_led);
        check("busy", int'(bus.busy), m_busy);
        check("duty0", int'(dut.duty_q[0]), m_duty[0]);
        check("duty9", int'(dut.duty_q[9]), m_duty[9]);
    endtask

    task automatic run_until_duty0(input int val);
        int n;
        n = 0;
        while (m_duty[0] != val && n < 200) begin
            cycle();
            n++;
        end
        check("duty0_reached", m_duty[0], val);
    endtask

    initial begin
        bus.pattern_in = 10'h3FF;
        bus.enable = 1'b1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("rst_led", int'(bus.led_out), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_duty0", int'(dut.duty_q[0]), 0);
        end
        bus.pattern_in = 10'h000;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        // fade up then settle
        bus.pattern_in = 10'h001;
        for (int k = 0; k < 30; k++) cycle();
        check("fade_up_final", int'(dut.duty_q[0]), MAXV);
        check("fade_up_busy", int'(bus.busy), 0);

        // reversal at mid-ramp
        bus.pattern_in = 10'h000;
        for (int k = 0; k < 30; k++) cycle();
        bus.pattern_in = 10'h001;
        run_until_duty0(8);
        bus.pattern_in = 10'h000;
        for (int k = 0; k < 20; k++) cycle();
        check("reverse_final", int'(dut.duty_q[0]), 0);

        // bypass latency
        bus.enable = 1'b0;
        bus.pattern_in = 10'h000;
        for (int k = 0; k < 4; k++) cycle();
        bus.pattern_in = 10'h2AA;
        cycle();
        cycle();
        check("bypass_lat", int'(bus.led_out), 10'h2AA);
        check("bypass_busy", int'(bus.busy), 0);
        bus.enable = 1'b1;
        bus.pattern_in = 10'h155;
        for (int k = 0; k < 30; k++) cycle();
        check("lockstep_dir", int'(dut.duty_q[0]) * 16 + int'(dut.duty_q[9]), MAXV * 16);

        // async reset mid-fade, pulse shorter than a clock and clear of any edge
        bus.pattern_in = 10'h000;
        for (int k = 0; k < 20; k++) cycle();
        bus.pattern_in = 10'h001;
        run_until_duty0(8);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_led", int'(bus.led_out), 0);
        check("async_busy", int'(bus.busy), 0);
        check("async_duty0", int'(dut.duty_q[0]), 0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 30; k++) cycle();

        // randomized pattern/enable activity
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) bus.pattern_in = 10'($urandom);
            if ($urandom_range(0, 60) == 0) bus.enable = ~bus.enable;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
